// File: rtl/wb_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : wb_frame_rx
// Summary  : Wishbone slave that deframes UART sensor packets (start, length,
//            payload, XOR checksum) into a one-frame buffer with a level IRQ.
//            Optional inter-byte idle timeout: define FRAMER_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module wb_frame_rx #(
  parameter int          MAX_LEN        = 64,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  START_BYTE     = 8'h7E
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        intr
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int WORDS = MAX_LEN / 4;

  typedef enum logic [1:0] {S_HUNT = 2'd0, S_LEN = 2'd1, S_PAY = 2'd2, S_CHK = 2'd3} state_t;

  state_t             r_state, w_next;
  logic [7:0]         r_buf [MAX_LEN];
  logic [7:0]         r_xor, r_exp_len, r_len;
  logic [7:0]         r_chkerr, r_drop, r_tmo;
  logic [IDX_W-1:0]   r_idx;
  logic               r_ready, r_ie, r_ack;
  logic [31:0]        r_dat;

  logic               w_acc, w_wr, w_release, w_ctrl_wr, w_err_clr, w_ready_eff;
  logic               w_store, w_len_ok, w_good, w_inc_chk, w_inc_drop, w_inc_tmo;
  logic [4:0]         w_reg;
  logic [7:0]         w_idx8;
  logic [IDX_W-1:0]   w_base;
  logic [31:0]        w_rdata;
  logic               w_unused;

  assign w_unused  = ^{wb_sel_i, wb_adr_i[31:7], wb_adr_i[1:0], wb_dat_i[31:2]};

  assign w_reg     = wb_adr_i[6:2];
  assign w_acc     = wb_stb_i & wb_cyc_i & ~r_ack;
  assign w_wr      = w_acc & wb_we_i;
  assign w_ctrl_wr = w_wr && (w_reg == 5'd1);
  assign w_release = w_ctrl_wr && wb_dat_i[0];
  assign w_err_clr = w_wr && (w_reg == 5'd2);
  // A RELEASE in the same cycle as a start byte frees the buffer first.
  assign w_ready_eff = r_ready & ~w_release;
  assign w_idx8    = 8'(r_idx);
  assign w_base    = IDX_W'({w_reg[3:0], 2'b00});

  assign wb_ack_o  = r_ack;
  assign wb_dat_o  = r_dat;
  assign intr      = r_ready & r_ie;

`ifdef FRAMER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] r_idle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 r_idle <= '0;
    else if (rx_valid)         r_idle <= '0;
    else if (r_state != S_HUNT) r_idle <= r_idle + IDLE_W'(1);
  end
`endif

  always_comb begin
    w_next     = r_state;
    w_store    = 1'b0;
    w_len_ok   = 1'b0;
    w_good     = 1'b0;
    w_inc_chk  = 1'b0;
    w_inc_drop = 1'b0;
    w_inc_tmo  = 1'b0;
    case (r_state)
      S_HUNT: begin
        if (rx_valid && rx_data == START_BYTE) begin
          if (w_ready_eff) w_inc_drop = 1'b1;
          else             w_next     = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          if (rx_data != 8'd0 && rx_data <= 8'(MAX_LEN)) begin
            w_len_ok = 1'b1;
            w_next   = S_PAY;
          end else begin
            w_inc_chk = 1'b1;
            w_next    = S_HUNT;
          end
        end
      end
      S_PAY: begin
        if (rx_valid) begin
          w_store = 1'b1;
          if (w_idx8 == r_exp_len - 8'd1) w_next = S_CHK;
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          w_next = S_HUNT;
          if (rx_data == r_xor) w_good    = 1'b1;
          else                  w_inc_chk = 1'b1;
        end
      end
      default: w_next = S_HUNT;
    endcase
`ifdef FRAMER_TIMEOUT_EN
    if (r_state != S_HUNT && !rx_valid && r_idle == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
      w_next    = S_HUNT;
      w_inc_tmo = 1'b1;
    end
`endif
  end

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      5'd0: w_rdata = {16'd0, r_len, 6'd0, r_ie, r_ready};
      5'd1: w_rdata = {30'd0, r_ie, 1'b0};
      5'd2: w_rdata = {8'd0, r_tmo, r_drop, r_chkerr};
      default: begin
        if (w_reg[4] && ({1'b0, w_reg[3:0]} < 5'(WORDS))) begin
          for (int k = 0; k < 4; k++) w_rdata[8*k +: 8] = r_buf[w_base + IDX_W'(k)];
        end
      end
    endcase
  end

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Payload storage carries no reset; its contents are don't-care until READY.
  always_ff @(posedge clk) begin
    if (w_store) r_buf[r_idx] <= rx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_HUNT;
      r_xor     <= '0;
      r_exp_len <= '0;
      r_idx     <= '0;
      r_len     <= '0;
      r_ready   <= 1'b0;
      r_ie      <= 1'b0;
      r_chkerr  <= '0;
      r_drop    <= '0;
      r_tmo     <= '0;
      r_ack     <= 1'b0;
      r_dat     <= '0;
    end else begin
      r_state <= w_next;
      r_ack   <= w_acc;
      r_dat   <= w_acc ? w_rdata : 32'd0;
      if (w_len_ok) begin
        r_exp_len <= rx_data;
        r_xor     <= rx_data;
        r_idx     <= '0;
      end else if (w_store) begin
        r_xor <= r_xor ^ rx_data;
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_good) begin
        r_ready <= 1'b1;
        r_len   <= r_exp_len;
      end else if (w_release) begin
        r_ready <= 1'b0;
      end
      if (w_ctrl_wr) r_ie <= wb_dat_i[1];
      if (w_err_clr) begin
        r_chkerr <= '0;
        r_drop   <= '0;
        r_tmo    <= '0;
      end else begin
        if (w_inc_chk)  r_chkerr <= sat_inc(r_chkerr);
        if (w_inc_drop) r_drop   <= sat_inc(r_drop);
        if (w_inc_tmo)  r_tmo    <= sat_inc(r_tmo);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_frame_rx
// Summary  : Self-checking bench for wb_frame_rx; frame-level reference model,
//            per-cycle compare, directed literals and randomized traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_frame_rx;

  localparam int TMO = 40;

  logic        clk, reset;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
  logic [7:0]  rx_data;
  logic        rx_valid, intr;

  int n_checks = 0;
  int n_errors = 0;

  wb_frame_rx #(.MAX_LEN(64), .TIMEOUT_CYCLES(TMO), .START_BYTE(8'h7E)) dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
    .rx_data(rx_data), .rx_valid(rx_valid), .intr(intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  int          m_phase, m_explen, m_len, m_chk, m_drop, m_tmo, m_idle;
  bit          m_ready, m_ie, m_ack;
  logic [7:0]  m_q[$];
  logic [7:0]  m_buf[64];
  logic [31:0] m_exp, m_mask;

  function automatic int s8(input int c);
    return (c > 255) ? 255 : c;
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] r);
    logic [31:0] v;
    v = 0;
    if (r == 0)      v = (m_len << 8) | (int'(m_ie) << 1) | int'(m_ready);
    else if (r == 1) v = int'(m_ie) << 1;
    else if (r == 2) v = (s8(m_tmo) << 16) | (s8(m_drop) << 8) | s8(m_chk);
    else if (r >= 16) for (int k = 0; k < 4; k++) v[8*k +: 8] = m_buf[4*(r-16)+k];
    return v;
  endfunction

  function automatic logic [31:0] mmask(input logic [4:0] r);
    logic [31:0] v;
    v = 32'hFFFF_FFFF;
    if (r >= 16) begin
      v = 0;
      for (int k = 0; k < 4; k++) if (m_ready && (4*(r-16)+k) < m_len) v[8*k +: 8] = 8'hFF;
    end
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_explen = 0; m_len = 0; m_chk = 0; m_drop = 0; m_tmo = 0; m_idle = 0;
      m_ready = 0; m_ie = 0; m_ack = 0; m_exp = 0; m_mask = 0;
      m_q.delete();
    end else begin
      bit acc, wr;
      logic [4:0] r;
      logic [7:0] x;
      acc = wb_stb_i && wb_cyc_i && !m_ack;
      r   = wb_adr_i[6:2];
      wr  = acc && wb_we_i;
      if (acc) begin
        m_exp  = mread(r);
        m_mask = mmask(r);
      end
      m_ack = acc;
      if (wr && r == 1) begin
        if (wb_dat_i[0]) m_ready = 0;
        m_ie = wb_dat_i[1];
      end
      if (rx_valid) begin
        m_idle = 0;
        case (m_phase)
          0: if (rx_data == 8'h7E) begin
               if (m_ready) m_drop++;
               else         m_phase = 1;
             end
          1: if (rx_data >= 1 && rx_data <= 64) begin
               m_explen = rx_data; m_q.delete(); m_phase = 2;
             end else begin
               m_chk++; m_phase = 0;
             end
          2: begin
               m_q.push_back(rx_data);
               if (m_q.size() == m_explen) m_phase = 3;
             end
          default: begin
               x = m_explen[7:0];
               foreach (m_q[i]) x ^= m_q[i];
               if (rx_data == x) begin
                 m_ready = 1; m_len = m_explen;
                 foreach (m_q[i]) m_buf[i] = m_q[i];
               end else m_chk++;
               m_phase = 0;
             end
        endcase
      end
`ifdef FRAMER_TIMEOUT_EN
      else if (m_phase != 0) begin
        m_idle++;
        if (m_idle == TMO) begin m_phase = 0; m_tmo++; end
      end
`endif
      if (wr && r == 2) begin m_chk = 0; m_drop = 0; m_tmo = 0; end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("ack", {31'd0, wb_ack_o}, {31'd0, m_ack});
      chk("intr", {31'd0, intr}, {31'd0, m_ready & m_ie});
      if (m_ack) chk("rdata", wb_dat_o & m_mask, m_exp & m_mask);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wb(input logic we, input logic [31:0] adr, input logic [31:0] wd, output logic [31:0] rd);
    int n;
    @(posedge clk); #1;
    wb_stb_i = 1; wb_cyc_i = 1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!wb_ack_o && n < 10);
    if (!wb_ack_o) chk("ack_timeout", 32'd0, 32'd1);
    rd = wb_dat_o;
    @(posedge clk); #1;
    wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] adr, input logic [31:0] exp, input logic [31:0] msk);
    logic [31:0] d;
    wb(1'b0, adr, 32'd0, d);
    chk(nm, d & msk, exp);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] wd);
    logic [31:0] d;
    wb(1'b1, adr, wd, d);
  endtask

  task automatic rx_with_write(input logic [7:0] b, input logic [31:0] adr, input logic [31:0] wd);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    wb_stb_i = 1; wb_cyc_i = 1; wb_we_i = 1; wb_adr_i = adr; wb_dat_i = wd;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0;
  endtask

  task automatic send_list(input logic [7:0] b[]);
    foreach (b[i]) send(b[i]);
  endtask

  task automatic send_frame(input int len, input bit bad);
    logic [7:0] x, b;
    send(8'h7E);
    send(len[7:0]);
    if (len >= 1 && len <= 64) begin
      x = len[7:0];
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        send(b);
        x ^= b;
      end
      if (bad) x ^= 8'h5A;
      send(x);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  fr[];
    reset = 1; rx_valid = 0; rx_data = 0;
    wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 4'hF; wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0;
    #23 reset = 0;

    rd_chk("reset_status", 32'h00, 32'h0, 32'hFFFF_FFFF);
    rd_chk("reset_errcnt", 32'h08, 32'h0, 32'hFFFF_FFFF);

    fr = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_list(fr);
    rd_chk("good_status", 32'h00, 32'h0301, 32'hFFFF_FFFF);
    rd_chk("good_buf0", 32'h40, 32'h0033_2211, 32'h00FF_FFFF);
    wr(32'h04, 32'h2);
    @(negedge clk); chk("intr_on", {31'd0, intr}, 32'd1);
    wr(32'h04, 32'h3);
    @(negedge clk); chk("intr_off", {31'd0, intr}, 32'd0);
    rd_chk("released_status", 32'h00, 32'h0302, 32'hFFFF_FFFF);

    fr = '{8'h7E, 8'h02, 8'hAA, 8'hBB, 8'h00};
    send_list(fr);
    rd_chk("badchk_errcnt", 32'h08, 32'h1, 32'hFFFF_FFFF);
    fr = '{8'h7E, 8'h01, 8'h5A, 8'h5B};
    send_list(fr);
    rd_chk("after_bad_status", 32'h00, 32'h0103, 32'hFFFF_FFFF);

    send_list(fr);
    rd_chk("overrun_errcnt", 32'h08, 32'h0101, 32'hFFFF_FFFF);
    rd_chk("overrun_buf", 32'h40, 32'h5A, 32'hFF);
    rx_with_write(8'h7E, 32'h04, 32'h3);
    fr = '{8'h02, 8'h10, 8'h20, 8'h32};
    send_list(fr);
    rd_chk("coincident_status", 32'h00, 32'h0203, 32'hFFFF_FFFF);
    rd_chk("coincident_errcnt", 32'h08, 32'h0101, 32'hFFFF_FFFF);
    rd_chk("coincident_buf", 32'h40, 32'h2010, 32'hFFFF);

    wr(32'h04, 32'h3);
    wr(32'h08, 32'h0);
    fr = '{8'h7E, 8'h00, 8'h7E, 8'h41};
    send_list(fr);
    rd_chk("lenerr_errcnt", 32'h08, 32'h2, 32'hFFFF_FFFF);
    send(8'h7E);
    rx_with_write(8'h00, 32'h08, 32'h0);
    rd_chk("clear_wins", 32'h08, 32'h0, 32'hFFFF_FFFF);

    send(8'h7E); send(8'h40);
    for (int i = 0; i < 64; i++) send(8'(i));
    send(8'h40);
    rd_chk("max_status", 32'h00, 32'h4003, 32'hFFFF_FFFF);
    rd_chk("max_buf15", 32'h7C, 32'h3F3E_3D3C, 32'hFFFF_FFFF);

    for (int i = 0; i < 260; i++) send(8'h7E);
    rd_chk("drop_sat", 32'h08, 32'hFF00, 32'hFF00);
    wr(32'h04, 32'h3);
    wr(32'h08, 32'h0);

    fr = '{8'h7E, 8'h04, 8'h01};
    send_list(fr);
    repeat (TMO + 10) @(posedge clk);
`ifdef FRAMER_TIMEOUT_EN
    rd_chk("timeout_errcnt", 32'h08, 32'h0001_0000, 32'hFFFF_FFFF);
`else
    rd_chk("timeout_errcnt", 32'h08, 32'h0, 32'hFFFF_FFFF);
`endif

    fr = '{8'h7E, 8'h03, 8'h11};
    send_list(fr);
    #3 reset = 1;
    #12 reset = 0;
    @(negedge clk); chk("reset_intr", {31'd0, intr}, 32'd0);
    rd_chk("midreset_status", 32'h00, 32'h0, 32'hFFFF_FFFF);
    rd_chk("midreset_errcnt", 32'h08, 32'h0, 32'hFFFF_FFFF);

    for (int it = 0; it < 400; it++) begin
      int p;
      p = $urandom_range(0, 9);
      if (p <= 4) begin
        int len;
        len = ($urandom_range(0, 9) == 0) ? ($urandom_range(0, 1) ? 0 : $urandom_range(65, 255))
                                          : $urandom_range(1, 8);
        send_frame(len, $urandom_range(0, 3) == 0);
      end else if (p == 5) begin
        send(8'($urandom));
      end else if (p == 6) begin
        wr(32'h04, {30'd0, 1'($urandom), 1'b1});
      end else if (p == 7 || p == 8) begin
        logic [31:0] d;
        case ($urandom_range(0, 4))
          0: a = 32'h00;
          1: a = 32'h04;
          2: a = 32'h08;
          3: a = 32'h40 + 4 * $urandom_range(0, 15);
          default: a = $urandom_range(0, 1) ? 32'h0C : 32'h20;
        endcase
        a = {$urandom_range(0, 32'h1FF_FFFF) & 25'h1FF_FFFF, a[6:2], 2'($urandom)};
        if (p == 8 && $urandom_range(0, 3) == 0) wb(1'b1, a, $urandom, d);
        else                                     wb(1'b0, a, 32'd0, d);
      end else begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
      end
    end

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
